// File: rtl/joint_step_converter_if.sv
// rtl/joint_step_converter_if.sv - request/result bundle between IK stage, converter and pulse generators
interface joint_step_converter_if #(
   parameter int CHANNELS = 2,
   parameter int ANGLE_W  = 13,
   parameter int STEP_W   = 9
);
   logic                        start;
   logic                        delta_mode;
   logic                        clear_pos;
   logic [CHANNELS*ANGLE_W-1:0] angles;
   logic [CHANNELS*STEP_W-1:0]  steps;
   logic [CHANNELS-1:0]         dir;
   logic [CHANNELS-1:0]         sat;
   logic                        busy;
   logic                        done;

   modport master (
      output start, delta_mode, clear_pos, angles,
      input  steps, dir, sat, busy, done
   );

   modport slave (
      input  start, delta_mode, clear_pos, angles,
      output steps, dir, sat, busy, done
   );
endinterface

// File: rtl/joint_step_converter.sv
// rtl/joint_step_converter.sv - multi-channel joint angle to stepper step converter
// One shared multiplier walks the channels; a second stage rounds, applies delta tracking and clips.
module joint_step_converter #(
   parameter int          CHANNELS   = 2,
   parameter int          ANGLE_W    = 13,
   parameter int          ANGLE_FRAC = 10,
   parameter int          SCALE_W    = 16,
   parameter int          SCALE_FRAC = 10,
   parameter int unsigned SCALE      = 32595,
   parameter int          STEP_W     = 9,
   parameter int          POS_W      = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   joint_step_converter_if.slave bus
);
   localparam int PROD_W = ANGLE_W + SCALE_W + 1;
   localparam int FRAC_W = ANGLE_FRAC + SCALE_FRAC;
   localparam int MAG_W  = PROD_W - FRAC_W;
   localparam int WIDE_W = MAG_W + POS_W + 2;
   localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SLOTS  = 1 << IDX_W;

   localparam logic [PROD_W-1:0]       ROUND_HALF = PROD_W'(1) << (FRAC_W - 1);
   localparam logic [WIDE_W-1:0]       STEP_MAX   = WIDE_W'((1 << STEP_W) - 1);
   localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(CHANNELS - 1);
   localparam logic signed [SCALE_W:0] SCALE_S    = {1'b0, SCALE_W'(SCALE)};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAIN, S_DONE} state_t;

   state_t                     state_q;
   logic [IDX_W-1:0]           idx_q;
   logic                       delta_q;
   logic signed [ANGLE_W-1:0]  angle_q [SLOTS];
   logic signed [PROD_W-1:0]   prod_q;
   logic [IDX_W-1:0]           prod_idx_q;
   logic                       prod_vld_q;
   logic signed [POS_W-1:0]    pos_q [SLOTS];
   logic [STEP_W-1:0]          work_steps_q [SLOTS];
   logic [SLOTS-1:0]           work_dir_q;
   logic [SLOTS-1:0]           work_sat_q;
   logic [CHANNELS*STEP_W-1:0] steps_q;
   logic [CHANNELS-1:0]        dir_q;
   logic [CHANNELS-1:0]        sat_q;
   logic                       busy_q;
   logic                       done_q;

   logic signed [PROD_W-1:0]   prod_d;
   logic [PROD_W-1:0]          prod_abs;
   logic [MAG_W-1:0]           mag;
   logic signed [WIDE_W-1:0]   abs_w;
   logic signed [WIDE_W-1:0]   res_w;
   logic [WIDE_W-1:0]          res_abs;
   logic signed [POS_W-1:0]    pos_d;
   logic [STEP_W-1:0]          step_d;
   logic                       dir_d;
   logic                       sat_d;

   // Rounding works on the magnitude so that halves round away from zero on both signs.
   always_comb begin
      prod_d   = PROD_W'(angle_q[idx_q]) * PROD_W'(SCALE_S);
      prod_abs = prod_q[PROD_W-1] ? -prod_q : prod_q;
      mag      = MAG_W'((prod_abs + ROUND_HALF) >> FRAC_W);
      abs_w    = WIDE_W'($signed({1'b0, mag}));
      if (prod_q[PROD_W-1]) begin
         abs_w = -abs_w;
      end
      pos_d    = abs_w[POS_W-1:0];
      res_w    = delta_q ? abs_w - WIDE_W'(pos_q[prod_idx_q]) : abs_w;
      res_abs  = res_w[WIDE_W-1] ? -res_w : res_w;
      sat_d    = res_abs > STEP_MAX;
      step_d   = sat_d ? STEP_MAX[STEP_W-1:0] : res_abs[STEP_W-1:0];
      dir_d    = ~res_w[WIDE_W-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         delta_q    <= 1'b0;
         prod_q     <= '0;
         prod_idx_q <= '0;
         prod_vld_q <= 1'b0;
         work_dir_q <= '0;
         work_sat_q <= '0;
         steps_q    <= '0;
         dir_q      <= '0;
         sat_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int s = 0; s < SLOTS; s++) begin
            angle_q[s]      <= '0;
            pos_q[s]        <= '0;
            work_steps_q[s] <= '0;
         end
      end else begin
         done_q     <= 1'b0;
         prod_vld_q <= 1'b0;

         if (prod_vld_q) begin
            pos_q[prod_idx_q]        <= pos_d;
            work_steps_q[prod_idx_q] <= step_d;
            work_dir_q[prod_idx_q]   <= dir_d;
            work_sat_q[prod_idx_q]   <= sat_d;
         end

         case (state_q)
            S_IDLE: begin
               if (bus.clear_pos) begin
                  for (int s = 0; s < SLOTS; s++) begin
                     pos_q[s] <= '0;
                  end
               end
               if (bus.start) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     angle_q[c] <= bus.angles[c*ANGLE_W +: ANGLE_W];
                  end
                  delta_q <= bus.delta_mode;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               prod_q     <= prod_d;
               prod_idx_q <= idx_q;
               prod_vld_q <= 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_q <= S_DRAIN;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DRAIN: begin
               state_q <= S_DONE;
            end
            S_DONE: begin
               // All channels land together so the pulse generators never see a mixed set.
               for (int c = 0; c < CHANNELS; c++) begin
                  steps_q[c*STEP_W +: STEP_W] <= work_steps_q[c];
                  dir_q[c]                    <= work_dir_q[c];
                  sat_q[c]                    <= work_sat_q[c];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.steps = steps_q;
   assign bus.dir   = dir_q;
   assign bus.sat   = sat_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_joint_step_converter.sv
// tb/tb_joint_step_converter.sv - randomized bench with behavioural model for joint_step_converter
module tb_joint_step_converter;
   localparam int     AW    = 13;
   localparam int     CA    = 2;
   localparam int     SWA   = 9;
   localparam int     CB    = 4;
   localparam int     SWB   = 6;
   localparam longint SCALE = 32595;

   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;
   always #5 clk = ~clk;

   joint_step_converter_if #(.CHANNELS(CA), .ANGLE_W(AW), .STEP_W(SWA)) bus_a ();
   joint_step_converter_if #(.CHANNELS(CB), .ANGLE_W(AW), .STEP_W(SWB)) bus_b ();

   joint_step_converter #(.CHANNELS(CA), .STEP_W(SWA)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
   joint_step_converter #(.CHANNELS(CB), .STEP_W(SWB)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: request-level view; a result is due C+2 edges after acceptance.
   int edge_cnt = 0;
   bit m_pend [2];
   int m_acc  [2];
   bit m_busy [2];
   bit m_done [2];
   int m_pos    [2][4];
   int m_nsteps [2][4];
   bit m_ndir   [2][4];
   bit m_nsat   [2][4];
   int m_steps  [2][4];
   bit m_dir    [2][4];
   bit m_sat    [2][4];
   int in_ang   [4];

   function automatic int round_steps(input int ang);
      longint p;
      longint m;
      p = longint'(ang) * SCALE;
      m = ((p < 0 ? -p : p) + (longint'(1) << 19)) >> 20;
      return int'(p < 0 ? -m : m);
   endfunction

   task automatic model_edge(input int d, input bit rst, input bit st, input bit dm, input bit cp,
                             input int nch, input int sw);
      int a;
      int r;
      int mag;
      int lim;
      logic [11:0] p12;
      if (rst) begin
         m_pend[d] = 0;
         m_busy[d] = 0;
         m_done[d] = 0;
         for (int c = 0; c < 4; c++) begin
            m_pos[d][c]   = 0;
            m_steps[d][c] = 0;
            m_dir[d][c]   = 0;
            m_sat[d][c]   = 0;
         end
      end else begin
         m_done[d] = 0;
         if (m_pend[d]) begin
            if (edge_cnt == m_acc[d] + nch + 2) begin
               for (int c = 0; c < 4; c++) begin
                  m_steps[d][c] = m_nsteps[d][c];
                  m_dir[d][c]   = m_ndir[d][c];
                  m_sat[d][c]   = m_nsat[d][c];
               end
               m_done[d] = 1;
               m_busy[d] = 0;
               m_pend[d] = 0;
            end
         end else begin
            if (cp) begin
               for (int c = 0; c < 4; c++) m_pos[d][c] = 0;
            end
            if (st) begin
               lim = (1 << sw) - 1;
               for (int c = 0; c < nch; c++) begin
                  a   = round_steps(in_ang[c]);
                  r   = dm ? a - m_pos[d][c] : a;
                  p12 = a[11:0];
                  m_pos[d][c]    = int'($signed(p12));
                  mag            = (r < 0) ? -r : r;
                  m_nsat[d][c]   = mag > lim;
                  m_nsteps[d][c] = (mag > lim) ? lim : mag;
                  m_ndir[d][c]   = r >= 0;
               end
               m_pend[d] = 1;
               m_acc[d]  = edge_cnt;
               m_busy[d] = 1;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      edge_cnt++;
      for (int c = 0; c < CA; c++) in_ang[c] = int'($signed(bus_a.angles[c*AW +: AW]));
      model_edge(0, reset_a, bus_a.start, bus_a.delta_mode, bus_a.clear_pos, CA, SWA);
      for (int c = 0; c < CB; c++) in_ang[c] = int'($signed(bus_b.angles[c*AW +: AW]));
      model_edge(1, reset_b, bus_b.start, bus_b.delta_mode, bus_b.clear_pos, CB, SWB);
   end

   always @(negedge clk) begin : compare
      logic [CA*SWA-1:0] ea;
      logic [CA-1:0]     da;
      logic [CA-1:0]     sa;
      logic [CB*SWB-1:0] eb;
      logic [CB-1:0]     db;
      logic [CB-1:0]     sb;
      for (int c = 0; c < CA; c++) begin
         ea[c*SWA +: SWA] = SWA'(m_steps[0][c]);
         da[c] = m_dir[0][c];
         sa[c] = m_sat[0][c];
      end
      for (int c = 0; c < CB; c++) begin
         eb[c*SWB +: SWB] = SWB'(m_steps[1][c]);
         db[c] = m_dir[1][c];
         sb[c] = m_sat[1][c];
      end
      chk("a_busy", bus_a.busy, m_busy[0]);
      chk("a_done", bus_a.done, m_done[0]);
      chk("a_steps", bus_a.steps, ea);
      chk("a_dir", bus_a.dir, da);
      chk("a_sat", bus_a.sat, sa);
      chk("b_busy", bus_b.busy, m_busy[1]);
      chk("b_done", bus_b.done, m_done[1]);
      chk("b_steps", bus_b.steps, eb);
      chk("b_dir", bus_b.dir, db);
      chk("b_sat", bus_b.sat, sb);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int d, input bit st, input bit dm, input bit cp,
                          input int a0, input int a1, input int a2, input int a3);
      if (d == 0) begin
         bus_a.start      = st;
         bus_a.delta_mode = dm;
         bus_a.clear_pos  = cp;
         bus_a.angles     = {AW'(a1), AW'(a0)};
      end else begin
         bus_b.start      = st;
         bus_b.delta_mode = dm;
         bus_b.clear_pos  = cp;
         bus_b.angles     = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
      end
   endtask

   function automatic bit get_done(input int d);
      return (d == 0) ? bus_a.done : bus_b.done;
   endfunction

   task automatic req(input int d, input bit dm, input bit cp,
                      input int a0, input int a1, input int a2, input int a3, output int lat);
      set_req(d, 1, dm, cp, a0, a1, a2, a3);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 1) set_req(d, 0, 0, 0, a0, a1, a2, a3);
         if (get_done(d)) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   function automatic int rand_angle();
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
         case ($urandom_range(0, 4))
            0:       return -4096;
            1:       return 4095;
            2:       return 0;
            3:       return -1;
            default: return 1;
         endcase
      end
      return int'($urandom_range(0, 8191)) - 4096;
   endfunction

   initial begin
      int lat;
      int nd;
      reset_a = 1'b1;
      reset_b = 1'b1;
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      reset_a = 1'b0;
      reset_b = 1'b0;
      step();
      chk("reset_steps_a", bus_a.steps, 64'd0);
      chk("reset_busy_a", bus_a.busy, 64'd0);

      req(0, 0, 0, 1024, -1024, 0, 0, lat);
      chk("abs1_latency", lat, 64'd4);
      chk("abs1_steps", bus_a.steps, {9'd32, 9'd32});
      chk("abs1_dir", bus_a.dir, 2'b01);
      chk("abs1_sat", bus_a.sat, 2'b00);

      req(0, 0, 0, 0, 4095, 0, 0, lat);
      chk("abs2_steps", bus_a.steps, {9'd127, 9'd0});
      chk("abs2_dir", bus_a.dir, 2'b11);

      req(0, 1, 1, 1024, 0, 0, 0, lat);
      chk("clear_delta_steps", bus_a.steps, {9'd0, 9'd32});
      chk("clear_delta_dir", bus_a.dir, 2'b11);

      req(0, 1, 0, -1024, 512, 0, 0, lat);
      chk("delta_steps", bus_a.steps, {9'd16, 9'd64});
      chk("delta_dir", bus_a.dir, 2'b10);

      req(0, 1, 0, 0, 0, 0, 0, lat);
      chk("delta_pos_steps", bus_a.steps, {9'd16, 9'd32});
      chk("delta_pos_dir", bus_a.dir, 2'b01);

      set_req(0, 1, 0, 0, 300, -700, 0, 0);
      nd = 0;
      for (int k = 1; k <= 14; k++) begin
         step();
         if (k == 1) set_req(0, 0, 0, 0, 300, -700, 0, 0);
         if (k == 2) set_req(0, 1, 0, 1, -5, 5, 0, 0);
         if (k == 3) set_req(0, 0, 0, 0, -5, 5, 0, 0);
         if (bus_a.done) nd++;
      end
      chk("busy_start_done_count", nd, 64'd1);

      req(1, 0, 0, 4095, 4095, -4096, 1024, lat);
      chk("b_sat_latency", lat, 64'd6);
      chk("b_sat_steps", bus_b.steps, {6'd32, 6'd63, 6'd63, 6'd63});
      chk("b_sat_flags", bus_b.sat, 4'b0111);
      chk("b_sat_dir", bus_b.dir, 4'b1011);

      req(1, 0, 0, 1024, 1024, 1024, 1024, lat);
      chk("b_nosat_steps", bus_b.steps, {6'd32, 6'd32, 6'd32, 6'd32});
      chk("b_nosat_flags", bus_b.sat, 4'b0000);

      set_req(1, 1, 0, 0, 4095, 4095, 4095, 4095);
      step();
      set_req(1, 0, 0, 0, 4095, 4095, 4095, 4095);
      step();
      reset_b = 1'b1;
      step();
      chk("b_reset_steps", bus_b.steps, 64'd0);
      chk("b_reset_busy", bus_b.busy, 64'd0);
      reset_b = 1'b0;
      nd = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus_b.done) nd++;
      end
      chk("b_reset_no_done", nd, 64'd0);
      req(1, 0, 0, -1024, 512, 0, 4095, lat);
      chk("b_after_reset_latency", lat, 64'd6);
      chk("b_after_reset_steps", bus_b.steps, {6'd63, 6'd0, 6'd16, 6'd32});
      chk("b_after_reset_dir", bus_b.dir, 4'b1110);
      chk("b_after_reset_sat", bus_b.sat, 4'b1000);

      for (int i = 0; i < 3000; i++) begin
         step();
         set_req(0, $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
                 rand_angle(), rand_angle(), 0, 0);
         set_req(1, $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
                 rand_angle(), rand_angle(), rand_angle(), rand_angle());
         reset_a = ($urandom_range(0, 299) == 0);
         reset_b = ($urandom_range(0, 299) == 0);
      end
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0, 0, 0, 0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      repeat (10) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
